// File: rtl/procyon_types.sv
// Shared fetch-path types and default configuration for the block fetch unit.
package procyon_types;

  localparam int FB_ADDR_WIDTH      = 32;
  localparam int FB_DATA_WIDTH      = 32;
  localparam int FB_FETCH_WIDTH     = 2;
  localparam int FB_MAX_OUTSTANDING = 4;
  localparam logic [FB_ADDR_WIDTH-1:0] FB_RESET_ADDR = '0;

  // Instructions are fixed at 4 bytes, so the block size follows from the slot count.
  function automatic int fb_block_bytes(input int fetch_width);
    return fetch_width * 4;
  endfunction

  function automatic int fb_offset_width(input int fetch_width);
    return $clog2(fetch_width * 4);
  endfunction

  typedef logic [FB_FETCH_WIDTH-1:0] fetch_mask_t;

  typedef struct packed {
    logic [FB_ADDR_WIDTH-1:0]                  pc;
    logic [FB_FETCH_WIDTH*FB_DATA_WIDTH-1:0]   data;
  } fetch_block_t;

endpackage

// File: rtl/fetch_block_unit_rsp_buffer.sv
// In-order response buffer: entries are allocated at tail, filled in order at the
// fill pointer and drained from head; flush frees everything in one cycle.
module fetch_rsp_buffer #(
  parameter int DEPTH      = 4,
  parameter int PC_WIDTH   = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MASK_WIDTH = 2,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  flush_i,
  input  logic                  alloc_i,
  input  logic [PC_WIDTH-1:0]   alloc_pc_i,
  input  logic [MASK_WIDTH-1:0] alloc_mask_i,
  input  logic                  fill_i,
  input  logic [DATA_WIDTH-1:0] fill_data_i,
  input  logic                  drain_i,
  output logic                  head_filled_o,
  output logic [PC_WIDTH-1:0]   head_pc_o,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic [MASK_WIDTH-1:0] head_mask_o,
  output logic                  full_o,
  output logic [CNT_W-1:0]      unfilled_cnt_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] head_q, head_d, fill_q, fill_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, unfilled_q, unfilled_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic             fill_en;

  logic [PC_WIDTH-1:0]   pc_q   [DEPTH];
  logic [MASK_WIDTH-1:0] mask_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A response with nothing waiting for it is dropped here rather than corrupting state.
  assign fill_en = fill_i & (unfilled_q != '0);

  always_comb begin
    head_d     = head_q;
    fill_d     = fill_q;
    tail_d     = tail_q;
    count_d    = count_q;
    unfilled_d = unfilled_q;
    filled_d   = filled_q;
    if (flush_i) begin
      head_d     = '0;
      fill_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      unfilled_d = '0;
      filled_d   = '0;
    end else begin
      if (alloc_i) begin
        filled_d[tail_q] = 1'b0;
        tail_d           = ptr_inc(tail_q);
      end
      if (fill_en) begin
        filled_d[fill_q] = 1'b1;
        fill_d           = ptr_inc(fill_q);
      end
      if (drain_i) begin
        filled_d[head_q] = 1'b0;
        head_d           = ptr_inc(head_q);
      end
      count_d    = count_q + CNT_W'(alloc_i) - CNT_W'(drain_i);
      unfilled_d = unfilled_q + CNT_W'(alloc_i) - CNT_W'(fill_en);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head_q     <= '0;
      fill_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
      filled_q   <= '0;
    end else begin
      head_q     <= head_d;
      fill_q     <= fill_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      unfilled_q <= unfilled_d;
      filled_q   <= filled_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_i && !flush_i) begin
      pc_q[tail_q]   <= alloc_pc_i;
      mask_q[tail_q] <= alloc_mask_i;
    end
    if (fill_en && !flush_i) begin
      data_q[fill_q] <= fill_data_i;
    end
  end

  assign head_filled_o  = (count_q != '0) & filled_q[head_q];
  assign head_pc_o      = pc_q[head_q];
  assign head_data_o    = data_q[head_q];
  assign head_mask_o    = mask_q[head_q];
  assign full_o         = (count_q == CNT_W'(DEPTH));
  assign unfilled_cnt_o = unfilled_q;

endmodule

// File: rtl/fetch_block_unit.sv
// Block instruction fetch: issues aligned block requests, matches in-order responses,
// drains complete blocks to the instruction FIFO, and squashes stale responses on redirect.
module fetch_block_unit
  import procyon_types::*;
#(
  parameter int ADDR_WIDTH      = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH      = FB_DATA_WIDTH,
  parameter int FETCH_WIDTH     = FB_FETCH_WIDTH,
  parameter int MAX_OUTSTANDING = FB_MAX_OUTSTANDING,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = FB_RESET_ADDR
) (
  input  logic                                     clk,
  input  logic                                     n_rst,
  input  logic                                     i_redirect,
  input  logic [ADDR_WIDTH-1:0]                    i_redirect_addr,
  output logic                                     o_req_valid,
  output logic [ADDR_WIDTH-1:0]                    o_req_addr,
  input  logic                                     i_req_ready,
  input  logic                                     i_rsp_valid,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0]        i_rsp_data,
  input  logic                                     i_insn_fifo_full,
  output logic [ADDR_WIDTH+FETCH_WIDTH*DATA_WIDTH-1:0] o_insn_fifo_data,
  output logic [FETCH_WIDTH-1:0]                   o_insn_fifo_mask,
  output logic                                     o_insn_fifo_wr_en
);

  localparam int BLOCK_BYTES = fb_block_bytes(FETCH_WIDTH);
  localparam int CNT_W       = $clog2(MAX_OUTSTANDING) + 1;
  localparam int BLK_DATA_W  = FETCH_WIDTH * DATA_WIDTH;

  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]       squash_q, squash_d, squash_pend;
  logic [ADDR_WIDTH-1:0]  word_off;
  logic [FETCH_WIDTH-1:0] alloc_mask;
  logic                   req_fire, squash_active, rsp_fill;
  logic                   buf_full, head_filled;
  logic [CNT_W-1:0]       unfilled_cnt;
  logic [ADDR_WIDTH-1:0]  head_pc;
  logic [BLK_DATA_W-1:0]  head_data;
  logic [FETCH_WIDTH-1:0] head_mask;

  assign o_req_addr = fetch_pc_q & ~ADDR_WIDTH'(BLOCK_BYTES - 1);
  assign word_off   = (fetch_pc_q & ADDR_WIDTH'(BLOCK_BYTES - 1)) >> 2;

  // Slots ahead of the fetch PC within the block are not part of the stream.
  always_comb begin
    alloc_mask = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      alloc_mask[i] = (ADDR_WIDTH'(i) >= word_off);
    end
  end

  // Reset gates issue so the request port is quiet while n_rst is held low.
  assign o_req_valid   = n_rst & ~buf_full & ~i_redirect;
  assign req_fire      = o_req_valid & i_req_ready;
  assign squash_active = (squash_q != '0);
  assign rsp_fill      = i_rsp_valid & ~squash_active;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (i_redirect) begin
      fetch_pc_d = i_redirect_addr;
    end else if (req_fire) begin
      fetch_pc_d = o_req_addr + ADDR_WIDTH'(BLOCK_BYTES);
    end
  end

  // Every outstanding unfilled request becomes a response to throw away; a response
  // arriving in the redirect cycle itself is already accounted for.
  always_comb begin
    squash_d    = squash_q;
    squash_pend = squash_q + unfilled_cnt;
    if (i_redirect) begin
      if (i_rsp_valid && squash_pend != '0) begin
        squash_d = squash_pend - CNT_W'(1);
      end else begin
        squash_d = squash_pend;
      end
    end else if (i_rsp_valid && squash_active) begin
      squash_d = squash_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fetch_pc_q <= RESET_ADDR;
      squash_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      squash_q   <= squash_d;
    end
  end

  fetch_rsp_buffer #(
    .DEPTH      (MAX_OUTSTANDING),
    .PC_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH (BLK_DATA_W),
    .MASK_WIDTH (FETCH_WIDTH)
  ) u_rsp_buffer (
    .clk            (clk),
    .n_rst          (n_rst),
    .flush_i        (i_redirect),
    .alloc_i        (req_fire),
    .alloc_pc_i     (fetch_pc_q),
    .alloc_mask_i   (alloc_mask),
    .fill_i         (rsp_fill),
    .fill_data_i    (i_rsp_data),
    .drain_i        (o_insn_fifo_wr_en),
    .head_filled_o  (head_filled),
    .head_pc_o      (head_pc),
    .head_data_o    (head_data),
    .head_mask_o    (head_mask),
    .full_o         (buf_full),
    .unfilled_cnt_o (unfilled_cnt)
  );

  assign o_insn_fifo_wr_en = head_filled & ~i_insn_fifo_full & ~i_redirect;
  assign o_insn_fifo_mask  = head_filled ? head_mask : '0;
  assign o_insn_fifo_data  = head_filled ? {head_pc, head_data} : '0;

  a_rsp_has_owner: assert property (@(posedge clk) disable iff (!n_rst)
    !(i_rsp_valid && !squash_active && unfilled_cnt == '0));

endmodule

// File: tb/tb_fetch_block_unit.sv
// Scoreboard bench for fetch_block_unit: stimulus queues expected requests and blocks,
// a monitor pops and compares whenever the DUT handshakes a request or writes the FIFO.
module tb_fetch_block_unit;
  import procyon_types::*;

  localparam int AW = 32;
  localparam int FW = 2;
  localparam int DW = 32;

  logic                clk = 1'b0;
  logic                n_rst = 1'b0;
  logic                i_redirect = 1'b0;
  logic [AW-1:0]       i_redirect_addr = '0;
  logic                o_req_valid;
  logic [AW-1:0]       o_req_addr;
  logic                i_req_ready = 1'b0;
  logic                i_rsp_valid = 1'b0;
  logic [FW*DW-1:0]    i_rsp_data = '0;
  logic                i_insn_fifo_full = 1'b0;
  logic [AW+FW*DW-1:0] o_insn_fifo_data;
  logic [FW-1:0]       o_insn_fifo_mask;
  logic                o_insn_fifo_wr_en;

  always #5 clk = ~clk;

  fetch_block_unit dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .i_redirect        (i_redirect),
    .i_redirect_addr   (i_redirect_addr),
    .o_req_valid       (o_req_valid),
    .o_req_addr        (o_req_addr),
    .i_req_ready       (i_req_ready),
    .i_rsp_valid       (i_rsp_valid),
    .i_rsp_data        (i_rsp_data),
    .i_insn_fifo_full  (i_insn_fifo_full),
    .o_insn_fifo_data  (o_insn_fifo_data),
    .o_insn_fifo_mask  (o_insn_fifo_mask),
    .o_insn_fifo_wr_en (o_insn_fifo_wr_en)
  );

  logic [AW-1:0] exp_req_q [$];
  fetch_block_t  exp_blk_q [$];
  fetch_mask_t   exp_mask_q [$];
  logic [AW-1:0] mem_addr_q [$];
  int            mem_due_q [$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_req(input logic [AW-1:0] a);
    exp_req_q.push_back(a);
  endtask

  task automatic expect_blk(input logic [AW-1:0] pc, input logic [AW-1:0] blk, input fetch_mask_t m);
    fetch_block_t b;
    b.pc   = pc;
    b.data = {blk + 32'd4, blk};
    exp_blk_q.push_back(b);
    exp_mask_q.push_back(m);
  endtask

  // mode 0: no response, 1: oldest pending response now, 2: oldest once 2 cycles old
  task automatic tick(input logic rdy, input int mode, input logic redir, input logic [AW-1:0] raddr);
    i_req_ready     = rdy;
    i_redirect      = redir;
    i_redirect_addr = raddr;
    i_rsp_valid     = 1'b0;
    i_rsp_data      = '0;
    if (mem_addr_q.size() > 0 && (mode == 1 || (mode == 2 && mem_due_q[0] <= cyc))) begin
      i_rsp_valid = 1'b1;
      i_rsp_data  = {mem_addr_q[0] + 32'd4, mem_addr_q[0]};
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    #1;
    if (o_req_valid && i_req_ready) begin
      mem_addr_q.push_back(o_req_addr);
      mem_due_q.push_back(cyc + 2);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    i_redirect  = 1'b0;
    i_rsp_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (6) tick(1'b0, 1, 1'b0, '0);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (n_rst) begin
        if (o_req_valid && i_req_ready) begin
          if (exp_req_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL req_unexpected: got addr %h expected none", o_req_addr);
          end else begin
            chk("req_addr", o_req_addr, exp_req_q.pop_front());
          end
        end
        if (o_insn_fifo_wr_en) begin
          if (exp_blk_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL fifo_unexpected: got data %h expected none", o_insn_fifo_data);
          end else begin
            chk("fifo_data", o_insn_fifo_data, exp_blk_q.pop_front());
            chk("fifo_mask", o_insn_fifo_mask, exp_mask_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    #1;
    chk("reset_req_valid", o_req_valid, 1'b0);
    chk("reset_wr_en", o_insn_fifo_wr_en, 1'b0);
    chk("reset_mask", o_insn_fifo_mask, 2'b00);
    @(negedge clk);
    n_rst = 1'b1;

    // streaming from reset, 2-cycle response latency
    for (int k = 0; k < 6; k++) begin
      expect_req(32'(k * 8));
      expect_blk(32'(k * 8), 32'(k * 8), 2'b11);
    end
    repeat (6) tick(1'b1, 2, 1'b0, '0);
    drain();

    // mid-block redirect target masks the leading slot
    expect_req(32'h100);
    expect_req(32'h108);
    expect_blk(32'h104, 32'h100, 2'b10);
    expect_blk(32'h108, 32'h108, 2'b11);
    tick(1'b1, 1, 1'b1, 32'h104);
    tick(1'b1, 1, 1'b0, '0);
    tick(1'b1, 1, 1'b0, '0);
    drain();

    // FIFO back-pressure fills the buffer, then a burst of four writes
    i_insn_fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      expect_req(32'h110 + 32'(k * 8));
      expect_blk(32'h110 + 32'(k * 8), 32'h110 + 32'(k * 8), 2'b11);
    end
    repeat (8) tick(1'b1, 2, 1'b0, '0);
    i_insn_fifo_full = 1'b0;
    i_req_ready = 1'b0;
    #1;
    chk("req_valid_while_full", o_req_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("burst_wr_en", o_insn_fifo_wr_en, 1'b1);
      tick(1'b0, 1, 1'b0, '0);
      #1;
    end
    tick(1'b1, 1, 1'b0, '0);
    drain();

    // redirect with three in flight and a response in the same cycle
    expect_req(32'h138);
    expect_req(32'h140);
    expect_req(32'h148);
    expect_req(32'h200);
    expect_blk(32'h200, 32'h200, 2'b11);
    repeat (3) tick(1'b1, 0, 1'b0, '0);
    tick(1'b1, 1, 1'b1, 32'h200);
    tick(1'b1, 1, 1'b0, '0);
    tick(1'b0, 1, 1'b0, '0);
    tick(1'b0, 1, 1'b0, '0);
    drain();

    // back-to-back redirects must keep the earlier squash
    expect_req(32'h208);
    expect_req(32'h400);
    expect_blk(32'h400, 32'h400, 2'b11);
    tick(1'b1, 0, 1'b0, '0);
    tick(1'b1, 0, 1'b1, 32'h300);
    tick(1'b1, 0, 1'b1, 32'h400);
    tick(1'b1, 1, 1'b0, '0);
    tick(1'b0, 1, 1'b0, '0);
    drain();

    // reset with a filled entry waiting and another in flight
    expect_req(32'h408);
    expect_req(32'h410);
    tick(1'b1, 0, 1'b0, '0);
    tick(1'b1, 1, 1'b0, '0);
    n_rst = 1'b0;
    mem_addr_q.delete();
    mem_due_q.delete();
    #1;
    chk("midreset_req_valid", o_req_valid, 1'b0);
    chk("midreset_wr_en", o_insn_fifo_wr_en, 1'b0);
    chk("midreset_mask", o_insn_fifo_mask, 2'b00);
    @(negedge clk);
    n_rst = 1'b1;
    expect_req(32'h0);
    expect_blk(32'h0, 32'h0, 2'b11);
    tick(1'b1, 0, 1'b0, '0);
    tick(1'b0, 1, 1'b0, '0);
    drain();

    chk("req_left_over", 128'(exp_req_q.size()), 128'd0);
    chk("blk_left_over", 128'(exp_blk_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_block_unit.md
Name: fetch_block_unit

Overview:
- Next-generation instruction fetch unit. Fetches FETCH_WIDTH aligned instructions per request over a valid/ready instruction-memory interface.
- Keeps up to MAX_OUTSTANDING requests in flight and buffers in-order responses in a reorder-free response buffer.
- Drains each complete block, with its PC and per-slot valid mask, into the instruction FIFO.
- On a redirect, squashes buffered blocks and in-flight responses.

Parameters:
ADDR_WIDTH, 32, address width in bits
DATA_WIDTH, 32, instruction width in bits (fixed 4-byte instructions)
FETCH_WIDTH, 2, instructions per fetch block; power of 2, at least 1
MAX_OUTSTANDING, 4, response-buffer depth and in-flight request limit; power of 2
RESET_ADDR, 0, PC after reset

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
i_redirect  in  1  flush and restart fetch
i_redirect_addr  in  ADDR_WIDTH  new PC (4-byte aligned)
o_req_valid  out  1  memory request valid
o_req_addr  out  ADDR_WIDTH  block-aligned request address
i_req_ready  in  1  memory accepts request
i_rsp_valid  in  1  response data valid; responses return in request order and cannot be back-pressured
i_rsp_data  in  FETCH_WIDTH*DATA_WIDTH  block data; slot 0 in the LSBs
i_insn_fifo_full  in  1  FIFO cannot accept a write
o_insn_fifo_data  out  ADDR_WIDTH+FETCH_WIDTH*DATA_WIDTH  {block PC, block data}
o_insn_fifo_mask  out  FETCH_WIDTH  per-slot valid mask
o_insn_fifo_wr_en  out  1  FIFO write strobe

Behaviour:
- Clock and reset are fixed: one clock (clk); reset n_rst is asynchronous and active-low.
- Reset state:
  - fetch_pc = RESET_ADDR.
  - Response buffer empty; squash_cnt = 0.
  - o_req_valid = 0, o_insn_fifo_wr_en = 0, o_insn_fifo_mask = 0.
- Block size B = FETCH_WIDTH*4 bytes.
- Request address: o_req_addr = fetch_pc with the low log2(B) bits cleared.
- Request issue:
  - o_req_valid = ~buffer_full & ~i_redirect. Combinational, so a request can issue in the first cycle after reset release.
  - buffer_full counts entries allocated but not yet drained; the limit is MAX_OUTSTANDING.
- On a request handshake (o_req_valid & i_req_ready):
  - Allocate an entry at the tail holding {pc = fetch_pc, mask, filled = 0}.
  - Mask bit i = (i >= fetch_pc word offset within the block). A mid-block PC therefore masks the leading slots.
  - fetch_pc <= o_req_addr + B. Address arithmetic wraps modulo 2^ADDR_WIDTH.
- On a response (i_rsp_valid):
  - If squash_cnt != 0: discard the data and decrement squash_cnt.
  - Otherwise: write the data into the oldest unfilled entry and set filled = 1.
  - A response with no unfilled entry and squash_cnt = 0 is a protocol error. It is ignored and flagged by an assertion.
- Drain:
  - o_insn_fifo_wr_en = head.filled & ~i_insn_fifo_full & ~i_redirect.
  - Data and mask are taken from the head entry; the head advances on a write.
  - A response arriving at edge t can be written to the FIFO at cycle t+1 at the earliest.
- Allocate, fill and drain may all occur in the same cycle. Occupancy tracking must handle every combination, including full-and-drain.
- Redirect (i_redirect = 1), in that cycle:
  - No request issues and no FIFO write occurs.
  - Next state: all buffer entries are freed and fetch_pc = i_redirect_addr.
  - squash_cnt <= squash_cnt + unfilled_cnt - (i_rsp_valid ? 1 : 0). unfilled_cnt counts entries allocated but not yet filled, including a request that completes its handshake this cycle (0 by construction).
  - Back-to-back redirects accumulate into squash_cnt.
  - The first request to the new address issues the cycle after the redirect.
- Width of squash_cnt and the occupancy counters: clog2(MAX_OUTSTANDING)+1 bits.
- Reset mid-operation: all state returns to its reset values immediately. Responses in flight at reset belong to the memory side's reset domain; the memory system is required to reset concurrently.

Decomposition:
- Add to procyon_types:
  - fetch_block_t = {pc, data}
  - fetch_mask_t
  - constants for B and the offset width, derived from FETCH_WIDTH
- Sub-module fetch_rsp_buffer:
  - Circular buffer with head, fill and tail pointers.
  - Allocate, fill, drain and flush ports.
  - Count outputs: full, unfilled_cnt.
- The top level holds fetch_pc, squash_cnt, the issue logic and the mask generation.

Test Plan:
1. Reset with RESET_ADDR=0, FETCH_WIDTH=2, i_req_ready=1, responses 2 cycles later → requests to 0x0, 0x8, 0x10…; FIFO writes carry mask 2'b11 and PCs in order.
2. Redirect to 0x104 → next request addr 0x100 with stored mask 2'b10; the following request goes to 0x108 with mask 2'b11.
3. Hold i_insn_fifo_full=1 while 4 responses arrive (MAX_OUTSTANDING=4) → o_req_valid drops after 4 allocations; release full → 4 consecutive writes, then requests resume.
4. Redirect with 3 requests in flight and a response in the same cycle → squash_cnt=2; the next 2 responses are discarded; the first response after them fills the entry for the redirect target.
5. Redirect asserted on two consecutive cycles with 1 in flight → the squash count accumulates correctly; no stale block reaches the FIFO.
6. Assert n_rst low while the buffer is half full → all outputs 0 asynchronously; after release the first request goes to RESET_ADDR.
